// File: rtl/core_acc_if.sv
// Bus bundle between a core_acc compute core and its controller.
// Groups the instruction and xmem write path, the accumulation controls and the SFP output stream.
// master drives instructions and controls; slave (the core) returns status and results.
interface core_acc_if #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int row     = 8,
  parameter int col     = 8
);
  logic [33:0]            inst_q;
  logic [row*bw-1:0]      D_xmem;
  logic                   xw_mode;
  logic                   acc_start;
  logic                   relu_en;
  logic                   ofifo_valid;
  logic                   acc_busy;
  logic                   sfp_valid;
  logic [psum_bw*col-1:0] sfp_out;
  logic                   acc_done;

  modport master (
    output inst_q, D_xmem, xw_mode, acc_start, relu_en,
    input  ofifo_valid, acc_busy, sfp_valid, sfp_out, acc_done
  );

  modport slave (
    input  inst_q, D_xmem, xw_mode, acc_start, relu_en,
    output ofifo_valid, acc_busy, sfp_valid, sfp_out, acc_done
  );
endinterface

// File: rtl/core_acc.sv
// Compute core: act/weight SRAMs feeding a compact corelet (L0, MAC column bank, OFIFO), psum SRAM, and a tap-accumulation/SFP engine.
// Latency: SRAM reads 1 cycle; output o appears NUM_TAPS+2+o*(NUM_TAPS+1) cycles after acc_start.
// No backpressure: results stream as one-cycle sfp_valid pulses; pmem writes issued while acc_busy are dropped.
module core_acc #(
  parameter int bw         = 4,
  parameter int psum_bw    = 16,
  parameter int row        = 8,
  parameter int col        = 8,
  parameter int NUM_TAPS   = 9,
  parameter int NUM_OUT    = 36,
  parameter int XMEM_DEPTH = 2048,
  parameter int WMEM_DEPTH = 2048,
  parameter int PMEM_DEPTH = 2048,
  parameter int ADD_WIDTH  = 11
) (
  input logic       clk,
  input logic       reset,
  core_acc_if.slave bus
);
  localparam int XW  = row * bw;
  localparam int PW  = psum_bw * col;
  localparam int KW  = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int OW  = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam int AW  = psum_bw + $clog2(NUM_TAPS);
  localparam logic signed [AW-1:0] SAT_MAX = AW'((1 <<< (psum_bw - 1)) - 1);
  localparam logic signed [AW-1:0] SAT_MIN = AW'(-(1 <<< (psum_bw - 1)));

  typedef enum logic [1:0] {S_IDLE, S_RD, S_LAST} state_t;

  // instruction decode; corelet control: [0] L0 write, [1] weight load, [2] execute, [3] OFIFO read
  logic                 w_p_cen_in, w_p_wen_in, w_x_cen, w_x_wen;
  logic [ADD_WIDTH-1:0] w_p_a_in, w_x_a;
  logic                 w_l0_wr, w_load, w_exec, w_of_rd, w_unused;
  assign w_p_cen_in = bus.inst_q[32];
  assign w_p_wen_in = bus.inst_q[31];
  assign w_p_a_in   = ADD_WIDTH'(bus.inst_q[30:20]);
  assign w_x_cen    = bus.inst_q[19];
  assign w_x_wen    = bus.inst_q[18];
  assign w_x_a      = ADD_WIDTH'(bus.inst_q[17:7]);
  assign w_l0_wr    = bus.inst_q[0];
  assign w_load     = bus.inst_q[1];
  assign w_exec     = bus.inst_q[2];
  assign w_of_rd    = bus.inst_q[3];
  assign w_unused   = ^{bus.inst_q[33], bus.inst_q[6:4]};

  // ---------------- activation / weight SRAMs ----------------
  logic [XW-1:0] r_xmem [XMEM_DEPTH];
  logic [XW-1:0] r_wmem [WMEM_DEPTH];
  logic [XW-1:0] r_xq, r_wq, w_l0_in;
  assign w_l0_in = bus.xw_mode ? r_wq : r_xq;

  // activation SRAM: enabled only when xw_mode selects it
  always_ff @(posedge clk) begin
    if (!(w_x_cen | bus.xw_mode)) begin
      if (!w_x_wen) r_xmem[w_x_a] <= bus.D_xmem;
      else          r_xq <= r_xmem[w_x_a];
    end
  end

  // weight SRAM: shares address and data with the activation SRAM
  always_ff @(posedge clk) begin
    if (!(w_x_cen | !bus.xw_mode)) begin
      if (!w_x_wen) r_wmem[w_x_a] <= bus.D_xmem;
      else          r_wq <= r_wmem[w_x_a];
    end
  end

  // ---------------- corelet: L0, weight-stationary column bank, OFIFO ----------------
  logic [XW-1:0] r_l0;
  logic [XW-1:0] r_wgt [col];

  // L0 captures the selected SRAM word; a load shifts it into the column weight chain
  always_ff @(posedge clk) begin
    if (w_l0_wr) r_l0 <= w_l0_in;
    if (w_load) begin
      r_wgt[0] <= r_l0;
      for (int c = 1; c < col; c++) r_wgt[c] <= r_wgt[c-1];
    end
  end

  logic signed [psum_bw-1:0] w_lane [col];
  logic signed [psum_bw-1:0] w_a, w_w;
  logic [PW-1:0]             w_of_din;

  // each column: dot product of unsigned activations with its signed weights
  always_comb begin
    w_a = '0;
    w_w = '0;
    w_of_din = '0;
    for (int c = 0; c < col; c++) begin
      w_lane[c] = '0;
      for (int r = 0; r < row; r++) begin
        w_a = psum_bw'(r_l0[r*bw +: bw]);
        w_w = psum_bw'($signed(r_wgt[c][r*bw +: bw]));
        w_lane[c] = w_lane[c] + w_a * w_w;
      end
      w_of_din[c*psum_bw +: psum_bw] = w_lane[c];
    end
  end

  logic [PW-1:0] r_of_mem [4];
  logic [2:0]    r_of_wp, r_of_rp;
  logic          w_of_empty, w_of_full;
  logic [PW-1:0] w_of_dout;
  assign w_of_empty = (r_of_wp == r_of_rp);
  assign w_of_full  = (r_of_wp[1:0] == r_of_rp[1:0]) && (r_of_wp[2] != r_of_rp[2]);
  assign w_of_dout  = r_of_mem[r_of_rp[1:0]];

  // OFIFO: execute pushes one column row, OFIFO read pops the head
  always_ff @(posedge clk) begin
    if (reset) begin
      r_of_wp <= '0;
      r_of_rp <= '0;
    end else begin
      if (w_exec && !w_of_full) begin
        r_of_mem[r_of_wp[1:0]] <= w_of_din;
        r_of_wp <= r_of_wp + 3'd1;
      end
      if (w_of_rd && !w_of_empty) r_of_rp <= r_of_rp + 3'd1;
    end
  end

  // ---------------- psum SRAM, shared with the accumulation engine ----------------
  state_t               r_state;
  logic [KW-1:0]        r_k;
  logic [OW-1:0]        r_o;
  logic                 r_busy, r_sfp_vld, r_done, r_relu;
  logic [PW-1:0]        r_sfp_out;
  logic [PW-1:0]        r_pmem [PMEM_DEPTH];
  logic [PW-1:0]        r_pq;
  logic                 w_own, w_p_cen, w_p_wen;
  logic [ADD_WIDTH-1:0] w_eng_a, w_p_a;

  // engine owns the port in every non-IDLE state; the instruction's pmem fields are ignored then
  assign w_own   = (r_state != S_IDLE);
  assign w_eng_a = ADD_WIDTH'(int'(r_k) * NUM_OUT + int'(r_o));
  assign w_p_cen = w_own ? 1'b0 : w_p_cen_in;
  assign w_p_wen = w_own ? 1'b1 : w_p_wen_in;
  assign w_p_a   = w_own ? w_eng_a : w_p_a_in;

  // psum SRAM: writes take the OFIFO head, reads land in r_pq one cycle later
  always_ff @(posedge clk) begin
    if (!w_p_cen) begin
      if (!w_p_wen) r_pmem[w_p_a] <= w_of_dout;
      else          r_pq <= r_pmem[w_p_a];
    end
  end

  // ---------------- accumulation / SFP ----------------
  logic signed [AW-1:0] r_acc [col];
  logic signed [AW-1:0] w_qx  [col];
  logic signed [AW-1:0] w_fin [col];
  logic [psum_bw-1:0]   w_sat;
  logic [PW-1:0]        w_res;

  // final tap sum per lane, saturated to the psum range, then optional ReLU
  always_comb begin
    w_res = '0;
    w_sat = '0;
    for (int c = 0; c < col; c++) begin
      w_qx[c]  = AW'($signed(r_pq[c*psum_bw +: psum_bw]));
      w_fin[c] = (NUM_TAPS == 1) ? w_qx[c] : r_acc[c] + w_qx[c];
      if (w_fin[c] > SAT_MAX)      w_sat = {1'b0, {(psum_bw-1){1'b1}}};
      else if (w_fin[c] < SAT_MIN) w_sat = {1'b1, {(psum_bw-1){1'b0}}};
      else                         w_sat = w_fin[c][psum_bw-1:0];
      if (r_relu && w_sat[psum_bw-1]) w_sat = '0;
      w_res[c*psum_bw +: psum_bw] = w_sat;
    end
  end

  // FSM: RD issues tap k of output o (absorbing the previous tap's Q), LAST absorbs the final tap and emits
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_k       <= '0;
      r_o       <= '0;
      r_busy    <= 1'b0;
      r_sfp_vld <= 1'b0;
      r_done    <= 1'b0;
      r_sfp_out <= '0;
      r_relu    <= 1'b0;
    end else begin
      r_sfp_vld <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.acc_start) begin
            r_relu  <= bus.relu_en;
            r_k     <= '0;
            r_o     <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RD;
          end
        end
        S_RD: begin
          // at k==1 the Q on hand is tap 0, which seeds the accumulator
          if (r_k != '0) begin
            for (int c = 0; c < col; c++)
              r_acc[c] <= (r_k == KW'(1)) ? w_qx[c] : r_acc[c] + w_qx[c];
          end
          if (r_k == KW'(NUM_TAPS - 1)) r_state <= S_LAST;
          else                          r_k <= r_k + 1'b1;
        end
        S_LAST: begin
          r_sfp_out <= w_res;
          r_sfp_vld <= 1'b1;
          r_k       <= '0;
          if (r_o == OW'(NUM_OUT - 1)) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_o     <= r_o + 1'b1;
            r_state <= S_RD;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ofifo_valid = !w_of_empty;
  assign bus.acc_busy    = r_busy;
  assign bus.sfp_valid   = r_sfp_vld;
  assign bus.sfp_out     = r_sfp_out;
  assign bus.acc_done    = r_done;
endmodule

// File: tb/tb_core_acc.sv
// Self-checking bench for core_acc: psum taps are backdoor-loaded, expected outputs are queued at acc_start
// and compared (value, cycle, done/busy) as sfp_valid pulses arrive; also covers collisions, reset abort, xmem path.
module tb_core_acc;
  localparam int BW = 4, PB = 16, ROW = 8, COL = 8, NT = 9, NO = 36;
  localparam int PW = PB * COL;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  core_acc_if #(.bw(BW), .psum_bw(PB), .row(ROW), .col(COL)) bus();
  core_acc #(.bw(BW), .psum_bw(PB), .row(ROW), .col(COL), .NUM_TAPS(NT), .NUM_OUT(NO),
             .XMEM_DEPTH(2048), .WMEM_DEPTH(2048), .PMEM_DEPTH(2048), .ADD_WIDTH(11))
    dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct { logic [PW-1:0] dat; int cyc; logic last; } exp_t;
  exp_t          sbq[$];
  logic [PW-1:0] m_pmem [NT*NO];
  logic [PW-1:0] last_out = '0;
  int n_checks = 0, n_fail = 0, n_pulse = 0;

  function automatic logic [33:0] mk_inst(logic pcen, logic pwen, logic [10:0] pa,
                                          logic xcen, logic xwen, logic [10:0] xa, logic [6:0] ctl);
    return {1'b0, pcen, pwen, pa, xcen, xwen, xa, ctl};
  endfunction

  localparam logic [33:0] INST_IDLE = {1'b0, 1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 11'd0, 7'd0};

  task automatic chk(string tag, logic [PW-1:0] obs, logic [PW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one comparison per cycle: either the next queued result, or quiet outputs holding their value
  task automatic monitor();
    exp_t e;
    if (bus.sfp_valid && sbq.size() > 0) begin
      e = sbq.pop_front();
      n_pulse++;
      chk("sfp_out", bus.sfp_out, e.dat);
      chk("sfp_cycle", PW'(cyc), PW'(e.cyc));
      chk("done_busy", PW'({bus.acc_done, bus.acc_busy}), PW'({e.last, !e.last}));
      last_out = e.dat;
    end else begin
      chk("quiet", PW'({bus.sfp_valid, bus.acc_done}), PW'(0));
      chk("sfp_hold", bus.sfp_out, last_out);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
  endtask

  task automatic load(int addr, logic [PW-1:0] v);
    dut.r_pmem[addr] <= v;
    m_pmem[addr] = v;
  endtask

  // fill modes: 0 all ones, 1 signed -5/+3, 2 saturating lanes plus random lanes
  task automatic fill(int mode);
    logic [PW-1:0] v;
    for (int a = 0; a < NT*NO; a++) begin
      v = '0;
      for (int l = 0; l < COL; l++) begin
        case (mode)
          0: v[l*PB +: PB] = 16'd1;
          1: v[l*PB +: PB] = (l == 0) ? 16'hFFFB : (l == 1) ? 16'd3 : 16'd0;
          default: v[l*PB +: PB] = (l == 0) ? 16'h7000 : (l == 1) ? 16'h8000 : 16'($urandom_range(0, 65535));
        endcase
      end
      load(a, v);
    end
  endtask

  function automatic logic [PW-1:0] model_out(int o, bit relu);
    logic [PW-1:0] r = '0;
    logic [PW-1:0] w;
    int s;
    for (int l = 0; l < COL; l++) begin
      s = 0;
      for (int k = 0; k < NT; k++) begin
        w = m_pmem[k*NO + o];
        s += int'($signed(w[l*PB +: PB]));
      end
      if (s > 32767) s = 32767;
      else if (s < -32768) s = -32768;
      if (relu && s < 0) s = 0;
      r[l*PB +: PB] = 16'(s);
    end
    return r;
  endfunction

  int run_base;

  task automatic start_run(bit relu);
    exp_t e;
    run_base = cyc;
    n_pulse = 0;
    for (int o = 0; o < NO; o++) begin
      e.dat  = model_out(o, relu);
      e.cyc  = run_base + NT + 2 + o * (NT + 1);
      e.last = (o == NO - 1);
      sbq.push_back(e);
    end
    bus.relu_en   = relu;
    bus.acc_start = 1'b1;
    tick();
    bus.acc_start = 1'b0;
    chk("busy_rise", PW'(bus.acc_busy), PW'(1));
  endtask

  task automatic drain();
    int budget = NO * (NT + 1) + 20;
    while (sbq.size() > 0 && budget > 0) begin
      tick();
      budget--;
    end
    chk("drain_left", PW'(sbq.size()), PW'(0));
    sbq.delete();
    chk("pulse_count", PW'(n_pulse), PW'(NO));
    tick();
    chk("busy_after", PW'(bus.acc_busy), PW'(0));
  endtask

  initial begin
    reset         = 1'b1;
    bus.inst_q    = INST_IDLE;
    bus.D_xmem    = '0;
    bus.xw_mode   = 1'b0;
    bus.acc_start = 1'b0;
    bus.relu_en   = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_busy", PW'(bus.acc_busy), PW'(0));
    chk("rst_sfp_out", bus.sfp_out, PW'(0));
    chk("rst_ofifo", PW'(bus.ofifo_valid), PW'(0));

    // xmem path: weight write must not touch the activation SRAM
    dut.r_xmem[3] <= 32'h12345678;
    bus.xw_mode = 1'b1;
    bus.D_xmem  = 32'hA5A5A5A5;
    bus.inst_q  = mk_inst(1'b1, 1'b1, 11'd0, 1'b0, 1'b0, 11'd3, 7'd0);
    tick();
    bus.xw_mode = 1'b0;
    bus.inst_q  = mk_inst(1'b1, 1'b1, 11'd0, 1'b0, 1'b1, 11'd3, 7'd0);
    tick();
    chk("xmem_act_rd", PW'(dut.w_l0_in), PW'(32'h12345678));
    bus.xw_mode = 1'b1;
    tick();
    chk("xmem_wgt_rd", PW'(dut.w_l0_in), PW'(32'hA5A5A5A5));
    bus.inst_q = INST_IDLE;

    // OFIFO push and pop
    bus.inst_q = mk_inst(1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 11'd0, 7'b0000100);
    tick();
    bus.inst_q = INST_IDLE;
    chk("ofifo_push", PW'(bus.ofifo_valid), PW'(1));
    bus.inst_q = mk_inst(1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 11'd0, 7'b0001000);
    tick();
    bus.inst_q = INST_IDLE;
    chk("ofifo_pop", PW'(bus.ofifo_valid), PW'(0));

    // basic run with a re-pulsed acc_start and a pmem write while busy
    fill(0);
    tick();
    start_run(1'b0);
    for (int i = 0; i < 40; i++) begin
      bus.acc_start = (i == 5);
      bus.inst_q = (i == 30) ? mk_inst(1'b0, 1'b0, 11'(NT*NO-1), 1'b1, 1'b1, 11'd0, 7'd0) : INST_IDLE;
      tick();
    end
    bus.acc_start = 1'b0;
    bus.inst_q    = INST_IDLE;
    drain();
    chk("pmem_keep_last", dut.r_pmem[NT*NO-1], m_pmem[NT*NO-1]);
    chk("pmem_keep_0", dut.r_pmem[0], m_pmem[0]);

    // signed taps, without and with ReLU
    fill(1);
    tick();
    start_run(1'b0);
    drain();
    chk("signed_lane0", PW'(last_out[15:0]), PW'(16'hFFD3));
    chk("signed_lane1", PW'(last_out[31:16]), PW'(16'd27));
    start_run(1'b1);
    drain();
    chk("relu_lane0", PW'(last_out[15:0]), PW'(16'h0000));

    // saturation both directions plus random lanes
    fill(2);
    tick();
    start_run(1'b0);
    drain();
    chk("sat_pos", PW'(last_out[15:0]), PW'(16'h7FFF));
    chk("sat_neg", PW'(last_out[31:16]), PW'(16'h8000));

    // reset mid-run at cycle 25 aborts without acc_done
    start_run(1'b0);
    while (cyc - run_base < 25) tick();
    reset = 1'b1;
    sbq.delete();
    last_out = '0;
    tick();
    chk("abort_busy", PW'(bus.acc_busy), PW'(0));
    chk("abort_out", bus.sfp_out, PW'(0));
    reset = 1'b0;
    repeat (15) tick();
    start_run(1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/core_acc.md
Name: core_acc

Overview:
- Next-generation compute core. It wraps the corelet (systolic array, L0, OFIFO) together with the activation, weight and psum SRAMs.
- Adds a built-in accumulation/SFP engine. After all kernel taps have been written to psum SRAM, the engine sums the per-tap partial sums for every output pixel, saturates the result, optionally applies ReLU, and streams it out on sfp_out.
- SRAM depths and tap/output counts are parameters, not fixed sizes.

Parameters:
- bw, 4, activation/weight bit width
- psum_bw, 16, psum bit width per column lane (signed)
- row, 8, array rows
- col, 8, array columns
- NUM_TAPS, 9, kernel taps (kij) accumulated per output
- NUM_OUT, 36, output pixels per tap
- XMEM_DEPTH, 2048, activation SRAM words
- WMEM_DEPTH, 2048, weight SRAM words
- PMEM_DEPTH, 2048, psum SRAM words; must be at least NUM_TAPS*NUM_OUT
- ADD_WIDTH, 11, SRAM address width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- inst_q  in  34  instruction word: [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem, [19] CEN_xmem, [18] WEN_xmem, [17:7] A_xmem, [6:0] corelet control; [33] reserved
- D_xmem  in  row*bw  write data for the activation/weight SRAM
- xw_mode  in  1  0 selects activation SRAM, 1 selects weight SRAM, for both xmem writes and L0 feed
- acc_start  in  1  one-cycle pulse that starts accumulation over all outputs
- relu_en  in  1  apply ReLU; latched when acc_start is accepted
- ofifo_valid  out  1  OFIFO holds a full column row
- acc_busy  out  1  accumulation engine owns the psum SRAM
- sfp_valid  out  1  sfp_out holds one valid output word
- sfp_out  out  psum_bw*col  accumulated output, one psum_bw lane per column
- acc_done  out  1  one-cycle pulse on the final output

Behaviour:
- Clock and reset: one clock domain, clk. reset is synchronous and active-high. On reset:
  - FSM goes to IDLE.
  - acc_busy=0, sfp_valid=0, acc_done=0, sfp_out=0.
  - Counters o and k are cleared.
  - SRAM contents are not cleared.
- Xmem path:
  - The activation SRAM is enabled only when xw_mode=0; the weight SRAM only when xw_mode=1. Chip enables are CEN_xmem|xw_mode and CEN_xmem|!xw_mode respectively.
  - Both SRAMs share A_xmem and D_xmem.
  - The L0 input is the Q output of the selected SRAM.
  - This path operates regardless of acc_busy.
- Psum SRAM, acc_busy=0: driven from inst_q pmem fields. Write data is the OFIFO output.
- Psum SRAM, acc_busy=1:
  - The engine drives CEN=0, WEN=1 and its own address.
  - inst_q pmem fields are ignored, so pmem writes are dropped.
- SRAM timing: reads have 1-cycle latency; the address is issued in cycle t and Q is valid in cycle t+1.
- Memory layout: address = k*NUM_OUT + o, with k in 0..NUM_TAPS-1 and o in 0..NUM_OUT-1.
- FSM state IDLE:
  - When acc_start=1, latch relu_en, set o=0, k=0, and go to RD. acc_busy rises the next cycle.
  - acc_start while not in IDLE is ignored.
- FSM state RD:
  - Issue a read of address k*NUM_OUT+o.
  - If a read was issued in the previous cycle, accumulate its Q. The first tap loads the accumulator; later taps add to it.
  - When k==NUM_TAPS-1, go to LAST; otherwise k++.
- FSM state LAST:
  - Accumulate the final Q.
  - Register the result into sfp_out and set sfp_valid=1 for the next cycle.
  - Set k=0.
  - If o==NUM_OUT-1, assert acc_done in the same cycle as the final sfp_valid and return to IDLE. Otherwise o++ and go to RD.
- Timing, with acc_start sampled in cycle 0:
  - Output o is valid (sfp_valid=1) in cycle NUM_TAPS+2+o*(NUM_TAPS+1).
  - sfp_valid is a one-cycle pulse per output.
  - acc_busy is high from cycle 1 through the last LAST cycle.
- Arithmetic, per lane:
  - Signed psum_bw inputs are summed in psum_bw+$clog2(NUM_TAPS) bits.
  - The sum is saturated to the signed psum_bw range [-2^(psum_bw-1), 2^(psum_bw-1)-1].
  - If relu_en was latched, negative results become 0.
  - Lanes are independent; lane c occupies bits [psum_bw*(c+1)-1 : psum_bw*c].
- sfp_out holds its last value between pulses.
- Reset during accumulation aborts the run immediately: IDLE, all outputs 0, no acc_done.
- The corelet is untouched by the engine; OFIFO activity may continue, but pmem writes during acc_busy are lost by design.

Test Plan:
- Basic accumulation: NUM_TAPS=9, NUM_OUT=36. Backdoor-load every lane of taps k=0..8 for o=0 with value 1. Pulse acc_start.
  -> First sfp_valid in cycle 11 with every lane =9.
  -> Exactly 36 sfp_valid pulses, spaced 10 cycles apart.
  -> acc_done coincides with the 36th pulse.
- Signed values and ReLU: lane0 taps all -5, lane1 taps all +3. With relu_en=0 -> lane0=-45, lane1=27. With relu_en=1 -> lane0=0, lane1=27.
- Saturation: all taps of lane0 =16'h7000 -> output 16'h7FFF. All taps =16'h8000 -> output 16'h8000.
- Collisions during a run:
  - acc_start re-pulsed mid-run -> ignored; pulse count stays 36.
  - A pmem write issued during acc_busy -> SRAM contents unchanged.
- Reset mid-run: assert reset at cycle 25 -> next cycle acc_busy=0, sfp_valid=0, sfp_out=0, and no acc_done. A new acc_start afterwards restarts from o=0.
- Xmem path: xw_mode=1 write D_xmem=32'hA5A5A5A5 at address 3, then xw_mode=0 read address 3 -> the activation SRAM is unchanged, and the weight SRAM reads back A5A5A5A5 when xw_mode=1.
